// File: rtl/bus_load_decoder_if.sv
// ---------------------------------------------------------------------------
// bus_load_decoder_if
// Request/enable bus of the load decoder. Keeps the spec's signal names.
//   Code, in_valid, in_ready : request handshake (5-bit destination select)
//   stall                    : downstream hold
//   Enable, en_valid         : one-cycle one-hot load enable and its flag
//   err, err_code, err_clr   : sticky illegal-code report and its clear
//   issued                   : wrapping count of enables issued
// master = requester side, slave = decoder side.
// ---------------------------------------------------------------------------
interface bus_load_decoder_if;
    logic [4:0]  Code;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic [23:0] Enable;
    logic        en_valid;
    logic        err;
    logic [4:0]  err_code;
    logic        err_clr;
    logic [7:0]  issued;

    modport master (
        output Code, in_valid, stall, err_clr,
        input  in_ready, Enable, en_valid, err, err_code, issued
    );

    modport slave (
        input  Code, in_valid, stall, err_clr,
        output in_ready, Enable, en_valid, err, err_code, issued
    );
endinterface

// File: rtl/bus_load_decoder.sv
// ---------------------------------------------------------------------------
// bus_load_decoder
// Queues legal destination codes (0..23) in a 2-entry FIFO and issues one
// registered one-hot load enable per code, oldest first. Illegal codes
// (24..31) are accepted but only recorded in a sticky error report.
// Ports:
//   clock : system clock, rising edge
//   clear : asynchronous active-low reset
//   bus   : bus_load_decoder_if.slave (request handshake, enable, error,
//           issued counter)
// ---------------------------------------------------------------------------
module bus_load_decoder (
    input  logic                 clock,
    input  logic                 clear,
    bus_load_decoder_if.slave    bus
);
    // FIFO occupancy doubles as the state
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]  count_q, count_d;
    logic [4:0]  slot_q [2];
    logic [4:0]  slot_d [2];
    logic [23:0] enable_q, enable_d;
    logic        en_valid_q, en_valid_d;
    logic        err_q, err_d;
    logic [4:0]  err_code_q, err_code_d;
    logic [7:0]  issued_q, issued_d;

    logic accept, push, bad, pop;

    assign accept = bus.in_valid && (count_q != FULL);
    assign push   = accept && (bus.Code < 5'd24);
    assign bad    = accept && (bus.Code >= 5'd24);
    // Pop decision uses pre-edge count, so a push into EMPTY never pops
    assign pop    = (count_q != EMPTY) && !bus.stall;

    always_comb begin
        count_d    = count_q;
        slot_d     = slot_q;
        enable_d   = '0;
        en_valid_d = 1'b0;
        issued_d   = issued_q;
        err_d      = err_q;
        err_code_d = err_code_q;

        // slot_q[0] is always the head; a pop shifts slot 1 down
        case ({push, pop})
            2'b10: begin
                slot_d[count_q[0]] = bus.Code;
                count_d            = count_q + 2'd1;
            end
            2'b01: begin
                slot_d[0] = slot_q[1];
                count_d   = count_q - 2'd1;
            end
            // Only reachable in ONE: head leaves, new code becomes head
            2'b11: slot_d[0] = bus.Code;
            default: ;
        endcase

        if (pop) begin
            enable_d   = 24'd1 << slot_q[0];
            en_valid_d = 1'b1;
            issued_d   = issued_q + 8'd1;
        end

        // A new illegal code beats a simultaneous clear
        if (bad) begin
            err_d = 1'b1;
            if (!err_q || bus.err_clr)
                err_code_d = bus.Code;
        end else if (bus.err_clr) begin
            err_d      = 1'b0;
            err_code_d = '0;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            count_q    <= EMPTY;
            slot_q[0]  <= '0;
            slot_q[1]  <= '0;
            enable_q   <= '0;
            en_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
            issued_q   <= '0;
        end else begin
            count_q    <= count_d;
            slot_q[0]  <= slot_d[0];
            slot_q[1]  <= slot_d[1];
            enable_q   <= enable_d;
            en_valid_q <= en_valid_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            issued_q   <= issued_d;
        end
    end

    assign bus.in_ready = (count_q != FULL);
    assign bus.Enable   = enable_q;
    assign bus.en_valid = en_valid_q;
    assign bus.err      = err_q;
    assign bus.err_code = err_code_q;
    assign bus.issued   = issued_q;
endmodule

// File: doc/bus_load_decoder.md
BUS_LOAD_DECODER -- requirements
Module: bus_load_decoder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, and these are the only clock and reset in the block.
REQ-002 Port clock  input  1  system clock; all state SHALL change on its rising edge only.
REQ-003 Port clear  input  1  asynchronous active-low reset.
REQ-004 Port Code  input  5  destination select; codes 0..23 name load targets, 24..31 are illegal.
REQ-005 Port in_valid  input  1  Code is presented this cycle.
REQ-006 Port in_ready  output  1  block can accept a request this cycle.
REQ-007 Port stall  input  1  downstream hold; when high, no new enable is issued.
REQ-008 Port Enable  output  24  registered one-hot load enable, bit k for code k.
REQ-009 Port en_valid  output  1  registered; high exactly when Enable is non-zero.
REQ-010 Port err  output  1  sticky: an illegal code was accepted.
REQ-011 Port err_code  output  5  first illegal code accepted since reset or err_clr.
REQ-012 Port err_clr  input  1  synchronous clear of err and err_code.
REQ-013 Port issued  output  8  count of enables issued, wraps 255->0.

Function
REQ-014 The block SHALL hold a 2-entry FIFO of legal codes with occupancy count in {0,1,2}, and this count SHALL be its state: EMPTY, ONE, FULL.
REQ-015 in_ready SHALL be combinational = (count != 2); a request is accepted on an edge where in_valid && in_ready.
REQ-016 An accepted legal code SHALL be written to the FIFO tail on that edge.
REQ-017 An accepted illegal code (24..31) SHALL complete the handshake, SHALL NOT be enqueued, and SHALL set err on that edge.
REQ-018 On the same edge, err_code SHALL capture the code if err was 0 beforehand; otherwise err_code is unchanged.
REQ-019 Pop rule: on each edge where the pre-edge count > 0 and stall == 0, the block SHALL remove the head entry, register Enable = 1 << head, set en_valid = 1, and increment issued mod 256.
REQ-020 On any edge with no pop, Enable SHALL be 0 and en_valid SHALL be 0, so each enable lasts exactly one cycle.
REQ-021 Latency: a legal code accepted at edge N into an empty FIFO with stall low SHALL produce Enable at edge N+1, visible for cycle N+1..N+2.
REQ-022 Count transitions:
  - push without pop: +1
  - pop without push: -1
  - push with pop: unchanged (allowed in ONE)
  - push with pop in EMPTY: impossible; the push lands and no pop occurs.
REQ-023 FIFO order SHALL be strict first-in first-out; back-to-back requests with stall low SHALL yield one Enable per cycle with no gaps after the first.
REQ-024 Stall asserted SHALL freeze the FIFO contents and zero Enable; pushes continue while count < 2.
REQ-025 err_clr SHALL clear err and err_code to 0 on the edge; if an illegal code is accepted on the same edge, err SHALL be 1 and err_code SHALL take the new code (set wins).
REQ-026 Enable SHALL never have more than one bit set.

Reset
REQ-027 While clear is low, asynchronously: count = 0 (EMPTY), Enable = 0, en_valid = 0, err = 0, err_code = 0, issued = 0; in_ready therefore reads 1.
REQ-028 A reset mid-operation SHALL discard all queued entries; no Enable from pre-reset requests SHALL appear after clear rises.
REQ-029 The first acceptance SHALL be possible on the first rising edge with clear high.

Verification
REQ-030 Single request, Code = 5, stall = 0 at edge 1 -> Enable = 0x000020 and en_valid = 1 after edge 2, both 0 after edge 3, issued = 1.
REQ-031 Codes 0, 23, 7 on consecutive edges with stall = 0 -> Enable = 0x000001, 0x800000, 0x000080 on three consecutive cycles; in_ready stays 1.
REQ-032 stall = 1, push 3 then 4 -> in_ready = 0 after the second push and third request not accepted; release stall -> Enable for bit 3 then bit 4, then in_ready = 1.
REQ-033 Code 26 accepted, then 30 accepted -> err = 1, err_code = 26, no Enable; err_clr pulse with Code 31 accepted on same edge -> err = 1, err_code = 31.
REQ-034 Two codes queued under stall, clear pulsed low mid-cycle -> all outputs 0 immediately, no Enable after clear rises, in_ready = 1.
REQ-035 256 legal requests issued -> issued wraps to 0, and Enable is one-hot or zero on every cycle.
